serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, meaning payload bits per frame (1..32).
REQ-002 Parameter BIT_CYCLES, default 2_777_777, meaning clk cycles per bit period (>=4).
REQ-003 Parameter MSB_FIRST, default 0, meaning 0 = first received bit lands in data[0], 1 = first received bit lands in data[DATA_W-1].
REQ-004 Port clk, input, 1, meaning single system clock; all logic on posedge.
REQ-005 Port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 Port init, input, 1, meaning receiver enable.
REQ-007 Port Data, input, 1, meaning asynchronous serial line; idle low.
REQ-008 Port data, output, DATA_W, meaning last good payload.
REQ-009 Port done, output, 1, meaning one-cycle pulse when data is updated.
REQ-010 Port busy, output, 1, meaning high in any state other than IDLE.
REQ-011 Port frame_err, output, 1, meaning one-cycle pulse on a bad stop bit.

Function
REQ-012 Data SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value (sd).
REQ-013 The frame format SHALL be: start bit high, DATA_W payload bits, optional parity bit (REQ-027), stop bit low.
REQ-014 States SHALL be IDLE, START, BITS, PARITY and STOP.
REQ-015 In IDLE with init=1, a 0->1 edge on sd SHALL load the bit counter with BIT_CYCLES/2 and move to START.
REQ-016 START, on expiry of the BIT_CYCLES/2 count:
- sd=1: reload BIT_CYCLES and go to BITS.
- sd=0: false start; return to IDLE with no pulse.
REQ-017 BITS SHALL sample sd every BIT_CYCLES cycles (mid-bit), DATA_W times, shifting per MSB_FIRST, then go to PARITY (macro defined) or STOP.
REQ-018 STOP, at the mid-bit sample:
- sd=0 (and parity ok): data <= shift register and done=1 on the next cycle.
- Otherwise: frame_err=1 for one cycle and data unchanged.
REQ-019 After STOP the block SHALL return to IDLE; a new frame requires a fresh 0->1 edge, so a line stuck high never retriggers.
REQ-020 Latency: the done pulse SHALL occur exactly 1 cycle after the stop-bit sample, i.e. (DATA_W+1[+1 parity])*BIT_CYCLES + BIT_CYCLES/2 + 1 cycles after the synchronized start edge.
REQ-021 init=0 in any state SHALL force IDLE on the next cycle; the partial frame is discarded and no done or frame_err pulse is issued.
REQ-022 done and frame_err SHALL never be high in the same cycle.
REQ-023 The bit counter SHALL be $clog2(BIT_CYCLES+1) bits wide; the payload index SHALL count 0..DATA_W-1 and never wrap.

Reset
REQ-024 While rst=1: state=IDLE, data=0, done=0, busy=0, frame_err=0, synchronizer flops=0, and all counters and the shift register =0.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately (asynchronous); after release the block SHALL wait for a new edge.
REQ-026 The first edge detection after reset release SHALL compare against the synchronizer reset value 0, so a line already high at release counts as an edge.

Configuration
REQ-027 With SERIAL_FRAME_RX_PARITY_EN defined:
- Add output parity_err (1 bit, reset 0).
- Add PARITY state: sample one extra bit; even parity over payload plus parity bit is required.
- Mismatch: parity_err pulses together with frame_err at stop; data unchanged, no done.
REQ-028 Without SERIAL_FRAME_RX_PARITY_EN: no parity_err port and no PARITY state; the frame is DATA_W+2 bits.

Verification (DATA_W=8, BIT_CYCLES=16, MSB_FIRST=0, macro undefined unless stated)
REQ-029 Frame 0xA5 sent LSB first, stop low -> done pulse once, data=0xA5, frame_err=0, done exactly 8*16+16+8+1 cycles after the synchronized edge.
REQ-030 High glitch of 4 cycles on idle line -> back to IDLE, no done, no frame_err, data holds previous value.
REQ-031 Frame 0x3C with stop bit high -> frame_err pulses once, data unchanged, no done; a following 0x11 frame -> data=0x11.
REQ-032 init dropped at payload bit 4 of frame 0xFF -> busy low next cycle, no pulses; re-enable and send 0x01 -> data=0x01.
REQ-033 rst pulsed mid-frame -> all outputs 0 immediately; the next frame 0x5A -> data=0x5A.
REQ-034 Macro defined, 0x07 with parity bit 1 -> done, data=0x07; same frame with parity bit 0 -> parity_err and frame_err pulse, data stays 0x07.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx -- mid-bit sampling receiver for a fixed-length serial frame.
//   Frame: start bit (high), DATA_W payload bits, optional parity bit, stop bit (low).
//   Idle line is low. The receiver arms on a 0->1 edge of the synchronized line.
// Optional feature: define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit
//   (PARITY state) and the parity_err output.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   init           receiver enable; low forces IDLE and drops any partial frame
//   Data           asynchronous serial input
//   data           last good payload
//   done           1-cycle pulse when data updates
//   busy           high whenever the FSM is not in IDLE
//   frame_err      1-cycle pulse on a bad stop bit (or parity failure)
//   parity_err     1-cycle pulse on parity mismatch (parity build only)
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 2_777_777,
  parameter int MSB_FIRST  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              Data,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              busy,
  output logic              frame_err
`ifdef SERIAL_FRAME_RX_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, BITS, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, BITS, STOP} state_t;
`endif

  state_t            state, nxt;
  logic              s1, sd, sd_q;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              tick, par_ok;
  logic              ld_half, ld_full, shift, commit, ferr;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic              par_bit, take_par, perr;
  // Even parity: payload XOR parity bit must be zero.
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  // Counter is loaded with a period and expires when it reaches 1, so a
  // load of N places the next sample exactly N cycles later.
  assign tick = (cnt == CW'(1));
  assign busy = (state != IDLE);

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                  input logic b);
    logic [DATA_W:0] t;
    if (MSB_FIRST != 0) begin
      t = {s, b};
      return t[DATA_W-1:0];
    end else begin
      t = {b, s};
      return t[DATA_W:1];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    ld_half = 1'b0;
    ld_full = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    ferr    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    take_par = 1'b0;
    perr     = 1'b0;
`endif
    if (!init) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (sd && !sd_q) begin
          nxt     = START;
          ld_half = 1'b1;
        end
        START: if (tick) begin
          if (sd) begin
            nxt     = BITS;
            ld_full = 1'b1;
          end else begin
            nxt = IDLE;  // false start, silently dropped
          end
        end
        BITS: if (tick) begin
          shift   = 1'b1;
          ld_full = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          if (idx == LAST) nxt = PARITY;
`else
          if (idx == LAST) nxt = STOP;
`endif
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: if (tick) begin
          take_par = 1'b1;
          ld_full  = 1'b1;
          nxt      = STOP;
        end
`endif
        STOP: if (tick) begin
          nxt = IDLE;
          if (!sd && par_ok) begin
            commit = 1'b1;
          end else begin
            ferr = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            perr = ~par_ok;
`endif
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      sd        <= 1'b0;
      sd_q      <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      s1        <= Data;
      sd        <= s1;
      sd_q      <= sd;
      done      <= commit;
      frame_err <= ferr;
      if (commit) data <= shreg;
      if (nxt == IDLE)  cnt <= '0;
      else if (ld_half) cnt <= HALF;
      else if (ld_full) cnt <= FULL;
      else              cnt <= cnt - 1'b1;
      if (nxt == IDLE)  idx <= '0;
      else if (shift)   idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (shift) shreg <= shift_in(shreg, sd);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      if (take_par) par_bit <= sd;
      parity_err <= perr;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx -- directed checks for serial_frame_rx with DATA_W=8,
// BIT_CYCLES=16, LSB first. Parity cases run only in the parity build.
module tb_serial_frame_rx;
  localparam int DW = 8;
  localparam int BC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init = 1'b0;
  logic          Data = 1'b0;
  logic [DW-1:0] data;
  logic          done, busy, frame_err;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic          parity_err;
`endif

  serial_frame_rx #(.DATA_W(DW), .BIT_CYCLES(BC), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst), .init(init), .Data(Data),
    .data(data), .done(done), .busy(busy), .frame_err(frame_err)
`ifdef SERIAL_FRAME_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_ferr = 0, n_both = 0, n_perr = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (frame_err)         n_ferr <= n_ferr + 1;
    if (done && frame_err) n_both <= n_both + 1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    if (parity_err)        n_perr <= n_perr + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    Data = b;
    repeat (BC) @(negedge clk);
  endtask

  // start, 8 payload bits LSB first, [parity], stop; line idles low afterwards
  task automatic send_frame(input logic [7:0] v, input logic stop, input logic par);
    drive_bit(1'b1);
    for (int i = 0; i < DW; i++) drive_bit(v[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
    Data = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int d0, f0, p0, c0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    rst  = 1'b0;
    init = 1'b1;
    repeat (4) @(negedge clk);

    // good frame 0xA5 with latency: done high 155 posedges after the drive point
    d0 = n_done; f0 = n_ferr; c0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_done_cnt", 32'(n_done - d0), 32'd1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    chk("a5_latency", 32'(done_cyc - c0), 32'd155);
    chk("a5_busy_after", 32'(busy), 32'h0);

    // 4-cycle glitch is a false start
    d0 = n_done; f0 = n_ferr;
    Data = 1'b1;
    repeat (4) @(negedge clk);
    Data = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_done_cnt", 32'(n_done - d0), 32'd0);
    chk("glitch_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    chk("glitch_data", 32'(data), 32'hA5);
    chk("glitch_busy", 32'(busy), 32'h0);

    // bad stop bit, then a good frame
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("badstop_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    chk("badstop_done_cnt", 32'(n_done - d0), 32'd0);
    chk("badstop_data", 32'(data), 32'hA5);
    d0 = n_done;
    send_frame(8'h11, 1'b0, 1'b0);
    chk("f11_done_cnt", 32'(n_done - d0), 32'd1);
    chk("f11_data", 32'(data), 32'h11);

    // init dropped during payload bit 4 of 0xFF
    d0 = n_done; f0 = n_ferr;
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (4) @(negedge clk);
    chk("drop_busy_before", 32'(busy), 32'h1);
    init = 1'b0;
    @(negedge clk);
    chk("drop_busy_after", 32'(busy), 32'h0);
    repeat (5 * BC) @(negedge clk);
    Data = 1'b0;
    repeat (20) @(negedge clk);
    chk("drop_done_cnt", 32'(n_done - d0), 32'd0);
    chk("drop_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    init = 1'b1;
    repeat (4) @(negedge clk);
    d0 = n_done;
    send_frame(8'h01, 1'b0, 1'b0);
    chk("f01_done_cnt", 32'(n_done - d0), 32'd1);
    chk("f01_data", 32'(data), 32'h01);

    // asynchronous reset mid-frame
    drive_bit(1'b1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);
    Data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    d0 = n_done;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("f5a_done_cnt", 32'(n_done - d0), 32'd1);
    chk("f5a_data", 32'(data), 32'h5A);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    d0 = n_done; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    chk("par_ok_done_cnt", 32'(n_done - d0), 32'd1);
    chk("par_ok_data", 32'(data), 32'h07);
    chk("par_ok_perr_cnt", 32'(n_perr - p0), 32'd0);
    d0 = n_done; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b0);
    chk("par_bad_perr_cnt", 32'(n_perr - p0), 32'd1);
    chk("par_bad_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    chk("par_bad_done_cnt", 32'(n_done - d0), 32'd0);
    chk("par_bad_data", 32'(data), 32'h07);
`else
    p0 = 0;
`endif

    chk("done_ferr_overlap", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
